// File: rtl/cache_mem_responder.sv
// Backing-store responder for a cache: single-cycle writes, fixed-latency read bursts.
// Line reads return four consecutive beats from the aligned 16-byte block, with no backpressure.
module cache_mem_responder #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned RD_LAT = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [1:0]   ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);
    localparam logic [2:0] TypeLine = 3'b100;
    localparam logic [3:0] WaitInit = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

    typedef enum logic [1:0] { StIdle, StWrCommit, StRdWait, StRdBurst } state_e;

    state_e            state_q;
    logic [31:0]       mem [0:(2**MEM_AW)-1];
    logic [MEM_AW-1:0] rd_word_q;
    logic              rd_line_q;
    logic [1:0]        beat_q;
    logic [3:0]        lat_q;

    logic              wr_fire;
    logic              rd_fire;
    logic [MEM_AW-1:0] emit_word;
    logic [MEM_AW-1:0] emit_idx;
    logic              emit_line;
    logic              emit_last;
    logic [1:0]        emit_beat;
    logic [31:0]       emit_data;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0],
                                wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    assign wr_rdy  = resetn & (state_q == StIdle);
    assign rd_rdy  = wr_rdy & ~wr_req;
    assign wr_fire = wr_req & wr_rdy;
    assign rd_fire = rd_req & rd_rdy;

    // In IDLE the beat source is the live request, so RD_LAT=1 can emit at the acceptance edge.
    always_comb begin
        emit_word = rd_word_q;
        emit_line = rd_line_q;
        emit_beat = beat_q;
        if (state_q == StIdle) begin
            emit_word = rd_addr[MEM_AW+1:2];
            emit_line = (rd_type == TypeLine);
            emit_beat = 2'd0;
        end
        emit_idx  = emit_line ? {emit_word[MEM_AW-1:2], emit_beat} : emit_word;
        emit_data = mem[emit_idx];
        emit_last = ~emit_line | (emit_beat == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            ret_valid <= 1'b0;
            ret_last  <= 2'b00;
            ret_data  <= 32'd0;
            beat_q    <= 2'd0;
            lat_q     <= 4'd0;
            rd_word_q <= '0;
            rd_line_q <= 1'b0;
        end else begin
            ret_valid <= 1'b0;
            ret_last  <= 2'b00;
            ret_data  <= 32'd0;
            unique case (state_q)
                StIdle: begin
                    if (wr_fire) begin
                        state_q <= StWrCommit;
                    end else if (rd_fire) begin
                        rd_word_q <= rd_addr[MEM_AW+1:2];
                        rd_line_q <= (rd_type == TypeLine);
                        beat_q    <= 2'd0;
                        if (RD_LAT == 1) begin
                            ret_valid <= 1'b1;
                            ret_data  <= emit_data;
                            ret_last  <= {1'b0, emit_last};
                            beat_q    <= emit_beat + 2'd1;
                            state_q   <= StRdBurst;
                        end else begin
                            lat_q   <= WaitInit;
                            state_q <= StRdWait;
                        end
                    end
                end
                StWrCommit: state_q <= StIdle;
                StRdWait: begin
                    if (lat_q == 4'd0) begin
                        ret_valid <= 1'b1;
                        ret_data  <= emit_data;
                        ret_last  <= {1'b0, emit_last};
                        beat_q    <= emit_beat + 2'd1;
                        state_q   <= StRdBurst;
                    end else begin
                        lat_q <= lat_q - 4'd1;
                    end
                end
                StRdBurst: begin
                    // The beat currently on the outputs was the last one: leave after its cycle.
                    if (ret_last[0]) begin
                        state_q <= StIdle;
                    end else begin
                        ret_valid <= 1'b1;
                        ret_data  <= emit_data;
                        ret_last  <= {1'b0, emit_last};
                        beat_q    <= emit_beat + 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory has no reset; contents survive resetn.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wr_type == TypeLine) begin
                for (int i = 0; i < 4; i++) begin
                    mem[{wr_addr[MEM_AW+1:4], 2'(i)}] <= wr_data[32*i +: 32];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_wstrb[b]) begin
                        mem[wr_addr[MEM_AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
